// File: rtl/dmem_access_unit_if.sv
// Load/store request and response bundle between the datapath and dmem_access_unit.
interface dmem_access_unit_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
  logic        misalign;

  // Datapath/controller side: issues requests, consumes results.
  modport master (
    output req, we, size, sign_ext, addr, wdata,
    input  rdata, ready, busy, misalign
  );

  // Memory unit side.
  modport slave (
    input  req, we, size, sign_ext, addr, wdata,
    output rdata, ready, busy, misalign
  );
endinterface

// File: rtl/dmem_access_unit.sv
// Multicycle data-memory access unit: byte/half/word loads with extension,
// sub-word stores by read-modify-write over a word-organised synchronous RAM.
module dmem_access_unit #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  dmem_access_unit_if.slave bus
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned HI_W  = 32 - ADDR_WIDTH - 2;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t                  state;
  logic                    we_q;
  logic [1:0]              size_q;
  logic                    sext_q;
  logic [1:0]              lane_q;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic [31:0]             wdata_q;
  logic [31:0]             old_q;
  logic [31:0]             mem [DEPTH];

  logic [31:0]             rd_word_c;
  logic [7:0]              byte_c;
  logic [15:0]             half_c;
  logic [31:0]             load_c;
  logic [31:0]             wr_word_c;
  logic                    err_c;
  logic [HI_W-1:0]         unused_addr_hi;

  // Upper address bits wrap away; they are intentionally not decoded.
  assign unused_addr_hi = bus.addr[31:ADDR_WIDTH+2];

  assign rd_word_c = mem[idx_q];

  // Alignment / reserved-size check on the incoming request.
  always_comb begin
    err_c = 1'b0;
    case (bus.size)
      2'b01:   err_c = bus.addr[0];
      2'b10:   err_c = (bus.addr[1:0] != 2'b00);
      2'b11:   err_c = 1'b1;
      default: err_c = 1'b0;
    endcase
  end

  // Lane selection and sign/zero extension of the fetched word for loads.
  always_comb begin
    byte_c = rd_word_c[7:0];
    case (lane_q)
      2'd1:    byte_c = rd_word_c[15:8];
      2'd2:    byte_c = rd_word_c[23:16];
      2'd3:    byte_c = rd_word_c[31:24];
      default: byte_c = rd_word_c[7:0];
    endcase
    half_c = lane_q[1] ? rd_word_c[31:16] : rd_word_c[15:0];
    load_c = rd_word_c;
    if (size_q == 2'b00) begin
      load_c = sext_q ? {{24{byte_c[7]}}, byte_c} : {24'd0, byte_c};
    end else if (size_q == 2'b01) begin
      load_c = sext_q ? {{16{half_c[15]}}, half_c} : {16'd0, half_c};
    end
  end

  // Merge of store data into the previously fetched word.
  always_comb begin
    wr_word_c = wdata_q;
    if (size_q == 2'b00) begin
      wr_word_c = old_q;
      case (lane_q)
        2'd1:    wr_word_c[15:8]  = wdata_q[7:0];
        2'd2:    wr_word_c[23:16] = wdata_q[7:0];
        2'd3:    wr_word_c[31:24] = wdata_q[7:0];
        default: wr_word_c[7:0]   = wdata_q[7:0];
      endcase
    end else if (size_q == 2'b01) begin
      wr_word_c = lane_q[1] ? {wdata_q[15:0], old_q[15:0]}
                            : {old_q[31:16], wdata_q[15:0]};
    end
  end

  // RAM port: write in WR, capture old word in RD (contents are never reset).
  always_ff @(posedge clk) begin
    if (state == WR) begin
      mem[idx_q] <= wr_word_c;
    end
    if (state == RD) begin
      old_q <= rd_word_c;
    end
  end

  // Access sequencer with registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      sext_q       <= 1'b0;
      lane_q       <= 2'b00;
      idx_q        <= '0;
      wdata_q      <= 32'd0;
      bus.rdata    <= 32'd0;
      bus.ready    <= 1'b0;
      bus.busy     <= 1'b0;
      bus.misalign <= 1'b0;
    end else begin
      bus.ready <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req) begin
            we_q     <= bus.we;
            size_q   <= bus.size;
            sext_q   <= bus.sign_ext;
            lane_q   <= bus.addr[1:0];
            idx_q    <= bus.addr[ADDR_WIDTH+1:2];
            wdata_q  <= bus.wdata;
            bus.busy <= 1'b1;
            if (err_c) begin
              state        <= DONE;
              bus.ready    <= 1'b1;
              bus.misalign <= 1'b1;
              bus.rdata    <= 32'd0;
            end else begin
              bus.misalign <= 1'b0;
              state        <= (bus.we && bus.size == 2'b10) ? WR : RD;
            end
          end
        end
        RD: begin
          if (we_q) begin
            state <= WR;
          end else begin
            state     <= DONE;
            bus.ready <= 1'b1;
            bus.rdata <= load_c;
          end
        end
        WR: begin
          state     <= DONE;
          bus.ready <= 1'b1;
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit with a word-array reference model.
module tb_dmem_access_unit;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [31:0] mem_m [1024];
  logic [31:0] rdata_m;

  dmem_access_unit_if bus ();

  dmem_access_unit #(.ADDR_WIDTH(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] load_m(input logic [31:0] word, input logic [1:0] sz,
                                         input logic sx, input logic [1:0] k);
    logic [31:0] v;
    logic [4:0]  sh;
    sh = {k, 3'b000};
    if (sz == 2'b10) return word;
    if (sz == 2'b00) begin
      v = (word >> sh) & 32'h0000_00FF;
      if (sx && v >= 32'd128) v = v | 32'hFFFF_FF00;
    end else begin
      v = (word >> sh) & 32'h0000_FFFF;
      if (sx && v >= 32'd32768) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  // One complete access: update the model, drive the request, measure ready latency.
  task automatic access(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] d, input bit pulse);
    int          idx;
    int          cyc;
    int          exp_cyc;
    logic        exp_mis;
    logic        err;
    logic [1:0]  k;
    logic [4:0]  sh;
    logic [31:0] mask;
    idx = int'(a[11:2]);
    k   = a[1:0];
    sh  = {k, 3'b000};
    err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    exp_mis = 1'b0;
    if (err) begin
      exp_cyc = 1; exp_mis = 1'b1; rdata_m = 32'd0;
    end else if (!w) begin
      exp_cyc = 2; rdata_m = load_m(mem_m[idx], sz, sx, k);
    end else if (sz == 2'b10) begin
      exp_cyc = 2; mem_m[idx] = d;
    end else begin
      exp_cyc = 3;
      mask = ((sz == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
      mem_m[idx] = (mem_m[idx] & ~mask) | ((d << sh) & mask);
    end

    @(negedge clk);
    bus.req = 1'b1; bus.we = w; bus.size = sz; bus.sign_ext = sx;
    bus.addr = a; bus.wdata = d;
    @(posedge clk); #1;
    bus.req = 1'b0;
    // Scramble inputs after acceptance; the unit must have latched its copy.
    bus.we = 1'($urandom); bus.size = 2'($urandom); bus.sign_ext = 1'($urandom);
    bus.addr = $urandom; bus.wdata = $urandom;
    cyc = 1;
    while (bus.ready !== 1'b1 && cyc < 8) begin
      if (pulse && cyc == 1) bus.req = 1'b1;
      @(posedge clk); #1;
      bus.req = 1'b0;
      cyc++;
    end
    check("ready_cycle", 32'(cyc), 32'(exp_cyc));
    check("rdata", bus.rdata, rdata_m);
    check("misalign", 32'(bus.misalign), 32'(exp_mis));
    check("busy_at_ready", 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    check("ready_pulse_len", 32'(bus.ready), 32'd0);
    check("busy_fall", 32'(bus.busy), 32'd0);
    if (pulse) begin
      @(posedge clk); #1;
      check("no_extra_access", 32'({bus.busy, bus.ready}), 32'd0);
    end
  endtask

  initial begin
    checks = 0; failures = 0; rdata_m = 32'd0;
    for (int i = 0; i < 1024; i++) mem_m[i] = 32'd0;
    bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.sign_ext = 1'b0;
    bus.addr = 32'd0; bus.wdata = 32'd0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_flags", 32'({bus.ready, bus.busy, bus.misalign}), 32'd0);
    @(negedge clk); rst = 1'b1;

    // Give the region used below defined contents.
    for (int i = 0; i < 16; i++) access(1'b1, 2'b10, 1'b0, 32'(i * 4), $urandom, 1'b0);

    // Word store/load and extension cases.
    access(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
    access(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'd0, 1'b0);
    check("lw_deadbeef", bus.rdata, 32'hDEAD_BEEF);
    access(1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'd0, 1'b0);
    check("lb_signed", bus.rdata, 32'hFFFF_FFDE);
    access(1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'd0, 1'b0);
    check("lbu", bus.rdata, 32'h0000_00DE);
    access(1'b0, 2'b01, 1'b1, 32'h0000_0010, 32'd0, 1'b0);
    check("lh_signed", bus.rdata, 32'hFFFF_BEEF);

    // Sub-word read-modify-write.
    access(1'b1, 2'b00, 1'b0, 32'h0000_0011, 32'hFFFF_FF55, 1'b0);
    access(1'b1, 2'b01, 1'b0, 32'h0000_0012, 32'hABCD_1234, 1'b0);
    access(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'd0, 1'b0);
    check("rmw_word", bus.rdata, 32'h1234_55EF);

    // Misaligned and reserved-size requests leave memory untouched.
    access(1'b0, 2'b10, 1'b0, 32'h0000_0012, 32'd0, 1'b0);
    access(1'b0, 2'b01, 1'b1, 32'h0000_0011, 32'd0, 1'b0);
    access(1'b1, 2'b11, 1'b0, 32'h0000_0010, 32'hFFFF_FFFF, 1'b0);
    access(1'b1, 2'b10, 1'b0, 32'h0000_0012, 32'h0BAD_0BAD, 1'b0);
    access(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'd0, 1'b0);
    check("mem_after_err", bus.rdata, 32'h1234_55EF);

    // Request while busy is dropped; address wraps modulo RAM size.
    access(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'd0, 1'b1);
    access(1'b1, 2'b10, 1'b0, 32'h0000_1000, 32'hA5A5_A5A5, 1'b0);
    access(1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'd0, 1'b0);
    check("wrap", bus.rdata, 32'hA5A5_A5A5);

    // Reset during the fetch of a sub-word store aborts it without a write.
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b00; bus.sign_ext = 1'b0;
    bus.addr = 32'h0000_0021; bus.wdata = 32'h0000_0077;
    @(posedge clk); #1;
    bus.req = 1'b0;
    rst = 1'b0;
    #1;
    rdata_m = 32'd0;
    check("midrst_rdata", bus.rdata, 32'd0);
    check("midrst_flags", 32'({bus.ready, bus.busy, bus.misalign}), 32'd0);
    @(negedge clk); @(negedge clk); rst = 1'b1;
    access(1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'd0, 1'b0);
    check("midrst_mem", bus.rdata, mem_m[8]);

    // Randomised mix over words 0..15 with random (ignored) upper address bits.
    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      a = $urandom;
      a[11:6] = 6'd0;
      access(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, 1'($urandom_range(0, 7) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_access_unit.md
# dmem_access_unit

Multicycle data-memory access unit for the MIPS core's load/store path. It consumes the memory request the datapath produces: the registered ALU result as the address, register-file read port 2 as store data, and the controller's access size. It owns a word-organised synchronous RAM, performs byte/halfword/word loads with sign or zero extension, and does sub-word stores by read-modify-write. It returns load data with a one-cycle `ready` pulse; the controller FSM waits on `ready` and loads the result into the memory data register.

## Interface
- `ADDR_WIDTH`, 10, word-address bits; RAM depth is 2^ADDR_WIDTH 32-bit words.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `req`  in  1  request strobe; sampled only in IDLE.
- `we`  in  1  1 = store, 0 = load.
- `size`  in  2  00 byte, 01 halfword, 10 word, 11 reserved (error).
- `sign_ext`  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data; sub-word data is taken from the low bits.
- `rdata`  out  32  load result.
- `ready`  out  1  one-cycle completion pulse.
- `busy`  out  1  high whenever the state is not IDLE.
- `misalign`  out  1  error flag; valid while `ready` is high.

## Operation
- States are IDLE, RD, WR and DONE.
- Acceptance: in IDLE with `req`=1, latch `we`, `size`, `sign_ext`, `addr` and `wdata`. Inputs are ignored at all other times, and `req` while busy is dropped.
- Alignment check at acceptance:
  - Halfword needs `addr[0]`=0.
  - Word needs `addr[1:0]`=00.
  - `size`=11 is always an error.
  - On error the next state is DONE with `misalign`=1. The RAM is not touched and `rdata` is forced to 0.
- Word index is `addr[ADDR_WIDTH+1:2]`. Upper address bits are ignored, so addresses wrap modulo RAM size.
- Byte lanes are little-endian: lane k = bits [8k+7:8k], k = `addr[1:0]`. Halfword lane h = `addr[1]`, bits [16h+15:16h].
- Load: IDLE → RD → DONE.
  - RD presents the read index; RAM read data is registered at the RD→DONE edge.
  - In DONE the selected lane is extended per `sign_ext`, driven on `rdata`, and `ready`=1.
- Word store: IDLE → WR → DONE. The RAM write of `wdata` occurs at the WR→DONE edge.
- Sub-word store: IDLE → RD → WR → DONE.
  - RD fetches the old word.
  - WR writes the old word with only the addressed lane(s) replaced by `wdata[7:0]` or `wdata[15:0]`.
- DONE → IDLE unconditionally.
- `rdata` updates only on load completion (or is forced to 0 on error); it holds otherwise, including across stores.
- `misalign` is 0 on every successful completion.
- RAM contents are not reset. Simulation initialises them to 0.

## Timing
- Reset values: state IDLE, `rdata`=0, `ready`=0, `busy`=0, `misalign`=0.
- Reset asserted mid-operation aborts immediately and returns to IDLE. A RAM write happens only if its WR edge occurred before reset asserted. No partial merge is written.
- Let cycle 0 be the IDLE cycle with `req`=1. `ready` is high in:
  - cycle 1 for an error;
  - cycle 2 for a load;
  - cycle 2 for a word store;
  - cycle 3 for a sub-word store.
- `busy` rises in cycle 1 and falls in the cycle after `ready`.
- Back-to-back: a new request is accepted in the cycle after DONE at the earliest. A load issued right after a store to the same word observes the stored value.
- `req` held high continuously means a new access starts on every IDLE cycle.

## Test plan
- Word store then load: store 0xDEADBEEF to 0x0000_0010, then load word from 0x10 → `ready` in cycle 2 of each access, `rdata`=0xDEADBEEF, `misalign`=0.
- Byte extension: with word 0x10 = 0xDEADBEEF, signed lb at 0x13 → 0xFFFFFFDE; unsigned lbu at 0x13 → 0x000000DE; signed lh at 0x10 → 0xFFFFBEEF.
- Sub-word RMW: sb 0x55 to 0x11, then sh 0x1234 to 0x12, then lw 0x10 → 0x1234_55EF; each store's `ready` arrives in cycle 3.
- Misalignment: lw at 0x12, lh at 0x11 and `size`=11 → `ready` in cycle 1, `misalign`=1, `rdata`=0, memory unchanged on a later lw.
- Busy/ignore and wrap: pulse `req` during a load's RD state → no extra access and exactly one `ready`. sw 0xA5A5A5A5 at 0x1000 (ADDR_WIDTH=10) then lw 0x0 → 0xA5A5A5A5.
- Reset mid-op: assert `rst`=0 during the RD state of a sub-word store → outputs return to reset values and the target word keeps its old value.
